// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter: single-outstanding I/D memory arbiter, D priority with I
// anti-starvation and response timeout. Define ARB_PERF_CNT_EN for counters.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] i_grant_cnt,
  output logic [31:0] d_grant_cnt,
  output logic [31:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner_d, owner_d_nxt;
  logic [2:0]  starve_cnt, starve_nxt;
  logic [7:0]  tmo_cnt, tmo_nxt;
  logic        mem_req_nxt, mem_we_nxt;
  logic [15:0] mem_addr_nxt, mem_wdata_nxt, rdata_nxt;
  logic        i_done_nxt, d_done_nxt, err_nxt, busy_nxt;
  logic        arb;
  logic        win_i;

  assign arb   = (state == IDLE) && (i_req || d_req);
  // I wins when alone, or when D has had its full quota of back-to-back grants
  assign win_i = i_req && (!d_req || (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_d    <= owner_d_nxt;
      starve_cnt <= starve_nxt;
      tmo_cnt    <= tmo_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      rdata      <= rdata_nxt;
      err        <= err_nxt;
      i_done     <= i_done_nxt;
      d_done     <= d_done_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_d_nxt   = owner_d;
    starve_nxt    = starve_cnt;
    tmo_nxt       = tmo_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rdata_nxt     = rdata;
    err_nxt       = err;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (arb) begin
          state_nxt   = ISSUE;
          mem_req_nxt = 1'b1;
          if (win_i) begin
            owner_d_nxt   = 1'b0;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = i_addr;
            mem_wdata_nxt = '0;
            starve_nxt    = '0;
          end else begin
            owner_d_nxt   = 1'b1;
            mem_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            if (i_req && (starve_cnt != STARVE_MAX)) begin
              starve_nxt = starve_cnt + 3'd1;
            end
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          mem_req_nxt = 1'b0;
          tmo_nxt     = '0;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        // A response in the last allowed cycle still wins over the timeout
        if (mem_rvalid) begin
          rdata_nxt = mem_we ? 16'h0000 : mem_rdata;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if ((state == WAIT) && (state_nxt == RESP)) begin
      i_done_nxt = !owner_d;
      d_done_nxt = owner_d;
    end
    busy_nxt = (state_nxt != IDLE);
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (arb && win_i) begin
        i_grant_cnt <= i_grant_cnt + 32'd1;
      end
      if (arb && !win_i) begin
        d_grant_cnt <= d_grant_cnt + 32'd1;
      end
      if ((state == IDLE) && i_req && d_req) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter: vector table, hand sequences and randomized rounds against a
// transaction-level reference model of mem_arbiter. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;
  localparam int MAX_WAIT     = 400;
  localparam int NV           = 10;
  localparam int NRAND        = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_done, d_done, err, busy, mem_req, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_grant_cnt, d_grant_cnt, conflict_cnt;
`endif

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory responder: grant after gnt_delay cycles of request, respond
  // rv_delay cycles after the grant cycle.
  logic [15:0] mem [0:255];
  logic [15:0] ref_mem [0:255];
  int          gnt_delay = 0, rv_delay = 0;
  int          phase = 0, cnt = 0;
  logic [15:0] lat_addr, lat_wdata;
  logic        lat_we;

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!rst_n) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (mem_req) begin
          if (cnt >= gnt_delay) begin
            mem_gnt = 1'b1; phase = 1; cnt = 0;
            lat_addr = mem_addr; lat_we = mem_we; lat_wdata = mem_wdata;
          end else cnt++;
        end
      end else begin
        if (cnt >= rv_delay) begin
          mem_rvalid = 1'b1;
          if (lat_we) begin
            mem[lat_addr[7:0]] = lat_wdata;
            mem_rdata = 16'($urandom);
          end else mem_rdata = mem[lat_addr[7:0]];
          phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state (transaction level)
  bit          i_pend = 0, d_pend = 0;
  int          starve = 0;
  logic        exp_we;
  logic [15:0] exp_addr, exp_wdata;

  task automatic wait_done(output int lat, output logic [1:0] who, output logic [15:0] rd,
                           output logic e, input bit scramble);
    bit got = 0;
    lat = 0; who = 2'b00; rd = '0; e = 1'b0;
    for (int k = 0; k < MAX_WAIT && !got; k++) begin
      @(negedge clk); lat++;
      if (mem_req) begin
        check("issue_bus", {mem_we, mem_addr, mem_wdata}, {exp_we, exp_addr, exp_wdata});
        if (scramble) begin
          d_addr = 16'($urandom); d_wdata = 16'($urandom); i_addr = 16'($urandom);
        end
      end
      if (i_done || d_done) begin
        got = 1; who = {i_done, d_done}; rd = rdata; e = err;
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL done_wait: got no done pulse, required one within %0d cycles", MAX_WAIT);
    end
  endtask

  task automatic drain();
    bit seen = 0;
    for (int k = 0; k < 200 && phase != 0; k++) begin
      @(negedge clk); if (i_done || d_done) seen = 1;
    end
    repeat (2) begin
      @(negedge clk); if (i_done || d_done) seen = 1;
    end
    check("no_stray_done", seen, 0);
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; i_pend = 0; d_pend = 0; starve = 0;
    rst_n = 0; repeat (2) @(negedge clk);
    rst_n = 1; @(negedge clk);
  endtask

  task automatic raise_i();
    i_pend = 1; i_addr = 16'($urandom); i_req = 1;
  endtask

  task automatic raise_d();
    d_pend = 1; d_we = 1'($urandom_range(0, 1));
    d_addr = 16'($urandom); d_wdata = 16'($urandom); d_req = 1;
  endtask

  // One arbitration round predicted from the pending set and starvation count
  task automatic round(output bit got_i);
    bit win_i, eerr;
    int lat;
    logic [1:0] who;
    logic [15:0] rd, erd;
    logic e;
    win_i = i_pend && (!d_pend || starve == STARVE_LIMIT);
    if (win_i) starve = 0;
    else if (i_pend && starve < STARVE_LIMIT) starve++;
    exp_we    = win_i ? 1'b0 : d_we;
    exp_addr  = win_i ? i_addr : d_addr;
    exp_wdata = win_i ? 16'h0 : d_wdata;
    eerr = (rv_delay >= TIMEOUT);
    erd  = (eerr || exp_we) ? 16'h0 : ref_mem[exp_addr[7:0]];
    if (exp_we) ref_mem[exp_addr[7:0]] = exp_wdata;
    wait_done(lat, who, rd, e, 0);
    check("rnd_owner", who, win_i ? 2'b10 : 2'b01);
    check("rnd_rdata", rd, erd);
    check("rnd_err", e, eerr);
    if (win_i) begin i_pend = 0; i_req = 0; end
    else begin d_pend = 0; d_req = 0; end
    @(negedge clk);
    check("rnd_pulse_end", {i_done, d_done, busy}, 0);
    got_i = win_i;
  endtask

  typedef struct {
    bit          is_i;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          gd;
    int          rd;
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [NV];

  initial begin
    int lat;
    logic [1:0] who;
    logic [15:0] rd;
    logic e;
    bit g;
    logic [9:0] exp_order;

    for (int i = 0; i < 256; i++) begin
      logic [15:0] v;
      v = 16'($urandom); mem[i] = v; ref_mem[i] = v;
    end
    mem[8'h40] = 16'hBEEF; ref_mem[8'h40] = 16'hBEEF;
    mem[8'h80] = 16'h1357; ref_mem[8'h80] = 16'h1357;

    //           is_i we addr      wdata     gd rd  rdata     err lat
    vt[0] = '{0, 0, 16'h0040, 16'h0000, 0, 0,  16'hBEEF, 0, 3};
    vt[1] = '{0, 1, 16'h0010, 16'h1234, 0, 0,  16'h0000, 0, 3};
    vt[2] = '{0, 0, 16'h0010, 16'h0000, 5, 0,  16'h1234, 0, 8};
    vt[3] = '{1, 0, 16'h0080, 16'h0000, 0, 2,  16'h1357, 0, 5};
    vt[4] = '{1, 0, 16'h0040, 16'h0000, 1, 3,  16'hBEEF, 0, 7};
    vt[5] = '{0, 1, 16'h0080, 16'hA5A5, 2, 1,  16'h0000, 0, 6};
    vt[6] = '{1, 0, 16'h0080, 16'h0000, 0, 0,  16'hA5A5, 0, 3};
    vt[7] = '{1, 0, 16'h0020, 16'h0000, 0, 70, 16'h0000, 1, 66};
    vt[8] = '{0, 0, 16'h0040, 16'h0000, 0, 63, 16'hBEEF, 0, 66};
    vt[9] = '{0, 0, 16'h0010, 16'h0000, 0, 0,  16'h1234, 0, 3};

    // Reset state
    @(negedge clk);
    check("reset_outputs", {i_done, d_done, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_after_reset", {busy, mem_req}, 0);

    // Single transactions from the vector table
    for (int v = 0; v < NV; v++) begin
      gnt_delay = vt[v].gd; rv_delay = vt[v].rd;
      exp_we = vt[v].we; exp_addr = vt[v].addr;
      exp_wdata = vt[v].is_i ? 16'h0 : vt[v].wdata;
      if (vt[v].is_i) begin
        i_addr = vt[v].addr; i_req = 1;
      end else begin
        d_we = vt[v].we; d_addr = vt[v].addr; d_wdata = vt[v].wdata; d_req = 1;
      end
      wait_done(lat, who, rd, e, 1);
      check("vec_latency", lat, vt[v].exp_lat);
      check("vec_owner", who, vt[v].is_i ? 2'b10 : 2'b01);
      check("vec_rdata", rd, vt[v].exp_rdata);
      check("vec_err", e, vt[v].exp_err);
      if (vt[v].we) ref_mem[vt[v].addr[7:0]] = vt[v].wdata;
      i_req = 0; d_req = 0;
      @(negedge clk);
      check("vec_pulse_end", {i_done, d_done, busy}, 0);
      drain();
    end

    // Continuous conflict: starvation limit forces every fifth grant to I
    do_reset();
    gnt_delay = 0; rv_delay = 0;
    exp_order = 10'b10000_10000;
    raise_i(); raise_d();
    for (int k = 0; k < 10; k++) begin
      round(g);
      check("conflict_order", g, exp_order[k]);
      if (k < 9) begin
        if (g) raise_i(); else raise_d();
      end
    end

    // Asynchronous reset while waiting on the memory response
    do_reset();
    gnt_delay = 0; rv_delay = 10;
    d_we = 0; d_addr = 16'h0040; d_wdata = 16'h0; d_req = 1;
    repeat (3) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    rst_n = 0; #1;
    check("rst_async_outputs", {i_done, d_done, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    d_req = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rv_delay = 0;
    exp_we = 0; exp_addr = 16'h0040; exp_wdata = 16'h0;
    d_req = 1;
    wait_done(lat, who, rd, e, 0);
    check("post_rst_latency", lat, 3);
    check("post_rst_owner", who, 2'b01);
    check("post_rst_rdata", rd, ref_mem[8'h40]);
    check("post_rst_err", e, 0);
    d_req = 0;
    @(negedge clk);
    drain();

    // Randomized rounds with random request mixes and memory delays
    do_reset();
    raise_i();
    if ($urandom_range(0, 1) == 1) raise_d();
    for (int r = 0; r < NRAND; r++) begin
      gnt_delay = $urandom_range(0, 3);
      rv_delay  = ($urandom_range(0, 15) == 0) ? 70 : $urandom_range(0, 4);
      round(g);
      if (!i_pend && $urandom_range(0, 1) == 1) raise_i();
      if (!d_pend && $urandom_range(0, 1) == 1) raise_d();
      if (!i_pend && !d_pend) raise_d();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
